// File: rtl/fifo_uart_word_tx_pkg.sv
// rtl/fifo_uart_word_tx_pkg.sv - shared UART framing definitions and state encodings
package fifo_uart_word_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, tick on the last clock of each bit
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Wrapping on tick restarts the count for the next bit with no dead cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_word_tx.sv
// rtl/fifo_uart_word_tx.sv - pops 32-bit fifo words and sends them as 4 LSB-first 8N1 bytes
module fifo_uart_word_tx
    import fifo_uart_word_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_POP,
    output logic                  TX,
    output logic                  BUSY,
    output logic                  WORD_DONE
);

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] shift;
    logic [2:0]            bit_idx;
    logic [1:0]            byte_idx;
    logic                  tick;

    // The counter idles cleared so the accept edge starts a full start bit.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (state == IDLE),
        .en    (state != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            TX        <= 1'b1;
            FIFO_POP  <= 1'b0;
            BUSY      <= 1'b0;
            WORD_DONE <= 1'b0;
        end else begin
            FIFO_POP  <= 1'b0;
            WORD_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE && !FIFO_EMPTY) begin
                        shift    <= FIFO_DATA;
                        byte_idx <= '0;
                        FIFO_POP <= 1'b1;
                        TX       <= 1'b0;
                        BUSY     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_idx <= '0;
                        TX      <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= shift >> 1;
                        if (bit_idx == LAST_BIT) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TX      <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 2'd1;
                            TX       <= 1'b0;
                            state    <= START;
                        end else begin
                            WORD_DONE <= 1'b1;
                            BUSY      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_word_tx.sv
// tb/tb_fifo_uart_word_tx.sv - fifo model, UART decoder and byte scoreboard around fifo_uart_word_tx
module tb_fifo_uart_word_tx;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [31:0] FIFO_DATA;
    logic        FIFO_EMPTY;
    logic        FIFO_POP;
    logic        TX;
    logic        BUSY;
    logic        WORD_DONE;

    fifo_uart_word_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (32)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .FIFO_DATA (FIFO_DATA),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_POP  (FIFO_POP),
        .TX        (TX),
        .BUSY      (BUSY),
        .WORD_DONE (WORD_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int          gaps_q[$];

    int pop_count = 0;
    int pop_cyc   = 0;
    bit prev_pop  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void refresh();
        FIFO_EMPTY = (fifo_q.size() == 0);
        FIFO_DATA  = FIFO_EMPTY ? 32'hDEAD_BEEF : fifo_q[0];
    endfunction

    // Expected bytes are queued at push time, least significant byte first.
    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        refresh();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((BUSY || fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(n < budget, name, n, budget);
    endtask

    task automatic wait_busy(input int budget, input string name);
        int n = 0;
        while (!BUSY && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(n < budget, name, n, budget);
    endtask

    // Monitor: fifo pop handling, pulse rules and UART frame decoding.
    bit         in_frame  = 0;
    bit         have_last = 0;
    bit         timing_ok = 1;
    int         samp      = 0;
    int         gap_cnt   = 0;
    logic [9:0] lvl;

    always @(negedge CLK) begin
        if (RESET !== 1'b1) begin
            in_frame = 0;
            prev_pop = 0;
        end else begin
            if (FIFO_POP) begin
                chk(fifo_q.size() > 0, "pop_while_empty", fifo_q.size(), 1);
                chk(!prev_pop, "double_pop", 1, 0);
                chk(BUSY == 1'b1, "pop_busy", BUSY, 1);
                pop_count++;
                pop_cyc = cyc;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                refresh();
            end
            prev_pop = FIFO_POP;
            if (WORD_DONE) chk(cyc - pop_cyc == 40 * CPB, "word_latency", cyc - pop_cyc, 40 * CPB);

            if (!in_frame) begin
                if (TX === 1'b0) begin
                    if (have_last) gaps_q.push_back(gap_cnt);
                    in_frame  = 1;
                    timing_ok = 1;
                    lvl[0]    = 1'b0;
                    samp      = 1;
                end else begin
                    gap_cnt++;
                end
            end else begin
                if (samp % CPB == 0) lvl[samp / CPB] = TX;
                else if (TX !== lvl[samp / CPB]) timing_ok = 0;
                samp++;
                if (samp == 10 * CPB) begin
                    logic [7:0] got;
                    logic [7:0] e;
                    got = lvl[8:1];
                    chk(timing_ok, "bit_timing", 0, 1);
                    chk(lvl[0] == 1'b0 && lvl[9] == 1'b1, "framing", {lvl[9], lvl[0]}, 2'b10);
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_byte", got, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(got == e, "byte", got, e);
                    end
                    in_frame  = 0;
                    have_last = 1;
                    gap_cnt   = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int p;
    int g0;
    int lows;

    initial begin
        RESET  = 1'b0;
        ENABLE = 1'b0;
        refresh();
        repeat (5) @(negedge CLK);
        chk(TX == 1'b1, "reset_tx", TX, 1);
        chk(FIFO_POP == 1'b0, "reset_pop", FIFO_POP, 0);
        chk(BUSY == 1'b0, "reset_busy", BUSY, 0);
        chk(WORD_DONE == 1'b0, "reset_word_done", WORD_DONE, 0);
        RESET = 1'b1;

        // Single word
        p = pop_count;
        push_word(32'hAAAA_5555);
        ENABLE = 1'b1;
        wait_idle(400, "single_timeout");
        chk(pop_count - p == 1, "single_pops", pop_count - p, 1);
        chk(FIFO_EMPTY == 1'b1, "single_empty", FIFO_EMPTY, 1);

        // Back-to-back words
        g0 = gaps_q.size();
        p  = pop_count;
        push_word(32'hAAAA_5555);
        push_word(32'hBBBB_6666);
        push_word(32'hCCCC_7777);
        push_word(32'hDDDD_8888);
        wait_idle(1000, "b2b_timeout");
        chk(pop_count - p == 4, "b2b_pops", pop_count - p, 4);
        chk(gaps_q.size() - g0 == 16, "b2b_gap_count", gaps_q.size() - g0, 16);
        for (int k = 1; k < 16 && g0 + k < gaps_q.size(); k++) begin
            if (k % 4 == 0) chk(gaps_q[g0 + k] <= 2, "b2b_word_gap", gaps_q[g0 + k], 2);
            else chk(gaps_q[g0 + k] == 0, "b2b_byte_gap", gaps_q[g0 + k], 0);
        end

        // ENABLE gating
        ENABLE = 1'b0;
        p = pop_count;
        push_word($urandom);
        push_word($urandom);
        lows = 0;
        repeat (60) begin
            @(negedge CLK);
            if (TX !== 1'b1) lows++;
        end
        chk(lows == 0, "gated_tx_low", lows, 0);
        chk(pop_count == p, "gated_pops", pop_count - p, 0);
        ENABLE = 1'b1;
        wait_busy(10, "gated_start_timeout");
        repeat (20) @(negedge CLK);
        ENABLE = 1'b0;
        begin
            int n = 0;
            while (BUSY && n < 300) begin
                @(negedge CLK);
                n++;
            end
            chk(n < 300, "gated_finish_timeout", n, 300);
        end
        repeat (100) @(negedge CLK);
        chk(pop_count - p == 1, "gated_one_pop", pop_count - p, 1);
        chk(fifo_q.size() == 1, "gated_waiting", fifo_q.size(), 1);
        chk(TX == 1'b1, "gated_idle_tx", TX, 1);
        ENABLE = 1'b1;
        wait_idle(400, "gated_resume_timeout");
        chk(pop_count - p == 2, "gated_total_pops", pop_count - p, 2);

        // Flush mid-word
        p = pop_count;
        push_word(32'h0123_4567);
        push_word(32'h89AB_CDEF);
        wait_busy(10, "flush_start_timeout");
        repeat (30) @(negedge CLK);
        while (fifo_q.size() > 0) begin
            void'(fifo_q.pop_back());
            repeat (4) void'(exp_q.pop_back());
        end
        refresh();
        wait_idle(400, "flush_timeout");
        repeat (50) @(negedge CLK);
        chk(pop_count - p == 1, "flush_pops", pop_count - p, 1);
        chk(BUSY == 1'b0, "flush_busy", BUSY, 0);
        chk(TX == 1'b1, "flush_tx", TX, 1);

        // Random words with ENABLE toggling
        p = pop_count;
        for (int i = 0; i < 8; i++) push_word($urandom);
        for (int i = 0; i < 10; i++) begin
            ENABLE = 1'($urandom_range(0, 1));
            repeat ($urandom_range(10, 80)) @(negedge CLK);
        end
        ENABLE = 1'b1;
        wait_idle(3000, "random_timeout");
        chk(pop_count - p == 8, "random_pops", pop_count - p, 8);

        // Reset mid-byte
        push_word(32'h5A5A_0000);
        wait_busy(10, "reset_start_timeout");
        repeat (10) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk(TX == 1'b1, "midreset_tx", TX, 1);
        chk(BUSY == 1'b0, "midreset_busy", BUSY, 0);
        chk(FIFO_POP == 1'b0, "midreset_pop", FIFO_POP, 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        p = pop_count;
        repeat (100) @(negedge CLK);
        chk(pop_count == p, "post_reset_pops", pop_count - p, 0);
        chk(TX == 1'b1, "post_reset_tx", TX, 1);
        chk(BUSY == 1'b0, "post_reset_busy", BUSY, 0);

        chk(exp_q.size() == 0, "bytes_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
